axi_llc_tag_store_plru: RTL and testbench
=========================================

# axi_llc_tag_store_plru

Parametrised next-generation LLC tag store with synchronous active-high reset, a self-clearing init sweep, configurable SRAM read latency, and tree-PLRU victim selection.
It sits between the LLC request pipeline and the hit/miss unit. It resolves one Lookup or Flush at a time: tag compare across all non-SPM ways, victim choice and evict reporting, then tag/state write-back on the response handshake.

## Interface
- `NumWays`, 4: set associativity; power of two, 2..16.
- `NumLines`, 256: lines per way; power of two, ≥2.
- `TagWidth`, 20: stored tag bits.
- `SramLatency`, 1: tag macro read latency in cycles, ≥1.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `spm_lock_i` in NumWays: way is SPM. It is never read, never hit, and never victimised.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when high with valid.
- `req_mode_i` in 1: 0 = Lookup, 1 = Flush.
- `req_index_i` in log2(NumLines): line index.
- `req_tag_i` in TagWidth: lookup tag.
- `req_dirty_i` in 1: Lookup is a write; line becomes dirty.
- `req_way_i` in NumWays: one-hot target way (Flush only).
- `res_valid_o` out 1: response valid.
- `res_ready_i` in 1: response accepted.
- `res_hit_o` out 1: Lookup hit.
- `res_way_o` out NumWays: one-hot hit, victim or flushed way; 0 if no allocation is possible.
- `res_evict_o` out 1: the victim or flushed line was valid and dirty.
- `res_evict_tag_o` out TagWidth: tag of the evicted line; 0 otherwise.
- `init_done_o` out 1: init sweep complete.

## Operation
- States: INIT, IDLE, READ, RESP. Reset (any cycle, including mid-operation) forces INIT.
  - On reset, the pending response is dropped and no SRAM write completes.
  - PLRU bits and the counters clear.
- INIT
  - Writes {val=0, dit=0, tag=0} to index 0..NumLines-1 in all ways, one index per cycle.
  - After the last index, `init_done_o` goes to 1 and the block enters IDLE.
- IDLE
  - `req_ready_o` = 1.
  - On handshake, the request is captured and SRAM reads are issued:
    - Lookup reads every way with spm_lock=0.
    - Flush reads only `req_way_i`.
  - Next state: READ.
- READ
  - Latency counter runs SramLatency cycles, then the block enters RESP.
- RESP: `res_valid_o` = 1. All outputs are held stable until `res_ready_i`.
- Lookup hit: the way has val=1, tag equal, and is unlocked.
  - Outputs: hit=1, way=hit way, evict=0.
- Lookup miss, victim priority:
  1. Lowest-index unlocked way with val=0.
  2. Otherwise the PLRU way, if it is unlocked.
  3. Otherwise the lowest-index unlocked way.
  - Outputs: evict = victim val&dit; evict_tag = victim tag.
  - All ways locked: way=0, hit=0, evict=0.
- Write-back happens in the RESP handshake cycle only, to `req_index_i` captured:
  - Miss with allocation: write {1, req_dirty, req_tag} to the victim.
  - Hit with req_dirty=1 and stored dit=0: write {1, 1, tag}.
  - Flush: write all-zero to `req_way_i`.
- PLRU
  - Storage: NumWays-1 bits per line, held in flops.
  - Updated on the Lookup handshake to point away from `res_way_o` (hit or allocated way).
  - Not updated on Flush or on no-allocation.
- Flush response: hit=0, way=`req_way_i`, evict = val&dit, evict_tag = stored tag.
- Multiple hits are illegal and covered by an assertion.

## Timing
- Reset values: `req_ready_o`=0, `res_valid_o`=0, `init_done_o`=0, all result fields 0.
- INIT lasts NumLines cycles after reset deassertion.
- Request accepted at edge t → `res_valid_o` high from cycle t+SramLatency+1.
- Response handshake at edge r → IDLE at r+1. Throughput is one request per SramLatency+2 cycles minimum.
- Result fields are 0 whenever `res_valid_o`=0.
- `spm_lock_i` is sampled at request acceptance. Changes while busy are ignored.

## Structure
- Shared package `axi_llc_pkg` holds:
  - the `tag_mode_e` enum (Lookup, Flush);
  - the `tag_data_t` packed struct {val, dit, tag}.
- Sub-module `axi_llc_plru_tree`, combinational:
  - victim = f(plru bits);
  - next_bits = f(bits, accessed one-hot way).
- The tag macros are `tc_sram` instances, one per way.

## Test plan
Defaults are used throughout (NumWays=4, NumLines=256, TagWidth=20, SramLatency=1).
- **Init.** Release reset → `req_ready_o`=0 for 256 cycles, then `init_done_o`=1.
- **Miss then hit.** Lookup idx 5, tag 0x123 → hit=0, way=0001, evict=0 at acceptance+2. Repeat → hit=1, way=0001.
- **Dirty eviction.** Fill idx 7 with dirty tags 0x10..0x13, then look up 0x14 → hit=0, evict=1, way and evict_tag match the PLRU model (way 0001, evict_tag 0x10).
- **SPM lock.** Lock 1111 → Lookup gives way=0, hit=0. Lock 0001 with the entry resident in way 0 → miss, victim never way 0.
- **Flush.** Flush way 0010 of a dirty line with tag 0xABC → evict=1, evict_tag=0xABC. A later Lookup of 0xABC misses.
- **Back-pressure and reset.**
  - Hold `res_ready_i`=0 for 10 cycles → outputs stable, no SRAM write.
  - Assert `rst_i` in RESP → next cycle `res_valid_o`=0 and INIT restarts.

Source files
------------

// File: rtl/axi_llc_pkg.sv
// Shared types for the LLC tag store.
//   tag_mode_e : request kind (Lookup / Flush)
//   tag_data_t : decoded tag-macro entry {val, dit, tag}; the tag field is
//                sized for the widest supported tag and zero-extended from
//                the stored TagWidth bits.
//   ST_*       : tag-store controller states
package axi_llc_pkg;

    localparam int unsigned MaxTagWidth = 64;

    typedef enum logic {
        TAG_LOOKUP = 1'b0,
        TAG_FLUSH  = 1'b1
    } tag_mode_e;

    typedef struct packed {
        logic                   val;
        logic                   dit;
        logic [MaxTagWidth-1:0] tag;
    } tag_data_t;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/axi_llc_plru_tree.sv
// Combinational tree-PLRU for one set.
//   bits_i      : NumWays-1 node bits, heap order (node n has children 2n+1, 2n+2)
//   access_i    : one-hot accessed way (all-zero leaves the bits unchanged)
//   victim_o    : one-hot way the tree currently points at
//   next_bits_o : bits after the access, every node on the path pointing away
// A node bit of 0 points at the lower-index half, 1 at the upper half.
module axi_llc_plru_tree #(
    parameter int unsigned NumWays = 4
) (
    input  logic [NumWays-2:0] bits_i,
    input  logic [NumWays-1:0] access_i,
    output logic [NumWays-1:0] victim_o,
    output logic [NumWays-2:0] next_bits_o
);

    localparam int unsigned Levels = $clog2(NumWays);
    localparam int unsigned NodeW  = Levels + 1;

    // Padded to a power of two so a NodeW-bit node index selects directly.
    logic [2*NumWays-1:0] bits_ext;
    logic [2*NumWays-1:0] next_ext;
    logic [NodeW-1:0]     vic_node;
    logic [NodeW-1:0]     acc_node;
    logic [Levels-1:0]    vic_idx;
    logic [Levels-1:0]    acc_idx;
    logic [Levels-1:0]    acc_path;
    logic                 unused_next;

    always_comb begin
        bits_ext              = '0;
        bits_ext[NumWays-2:0] = bits_i;
        vic_node              = '0;
        vic_idx               = '0;
        for (int lvl = 0; lvl < Levels; lvl++) begin
            vic_idx  = (vic_idx << 1) | Levels'(bits_ext[vic_node]);
            vic_node = (vic_node << 1) + NodeW'(1) + NodeW'(bits_ext[vic_node]);
        end
        victim_o = NumWays'(1) << vic_idx;
    end

    always_comb begin
        acc_idx = '0;
        for (int w = 0; w < NumWays; w++) begin
            if (access_i[w]) acc_idx = Levels'(w);
        end
        next_ext = bits_ext;
        acc_node = '0;
        acc_path = acc_idx;
        if (|access_i) begin
            // Walk MSB-first down the accessed way's path.
            for (int lvl = 0; lvl < Levels; lvl++) begin
                next_ext[acc_node] = ~acc_path[Levels-1];
                acc_node = (acc_node << 1) + NodeW'(1) + NodeW'(acc_path[Levels-1]);
                acc_path = acc_path << 1;
            end
        end
        next_bits_o = next_ext[NumWays-2:0];
    end

    assign unused_next = ^next_ext[2*NumWays-1:NumWays-1];

endmodule

// File: rtl/tc_sram.sv
// Single-port tag macro model with registered read.
//   clk_i   : clock
//   req_i   : access enable; we_i selects write (1) or read (0)
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data, valid Latency cycles after a read request and
//             held until the next read (writes do not disturb it)
module tc_sram #(
    parameter int unsigned NumWords  = 256,
    parameter int unsigned DataWidth = 22,
    parameter int unsigned Latency   = 1,
    localparam int unsigned AddrWidth = $clog2(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_reg  [NumWords];
    logic [DataWidth-1:0] pipe_reg [Latency];

    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            mem_reg[addr_i] <= wdata_i;
        end
        if (req_i && !we_i) begin
            pipe_reg[0] <= mem_reg[addr_i];
        end
        for (int s = 1; s < Latency; s++) begin
            pipe_reg[s] <= pipe_reg[s-1];
        end
    end

    assign rdata_o = pipe_reg[Latency-1];

endmodule

// File: rtl/axi_llc_tag_store_plru.sv
// LLC tag store: resolves one Lookup or Flush at a time against NumWays tag
// macros, picks a victim with tree-PLRU, and writes back on the response
// handshake. A sweep after reset clears every entry.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   spm_lock_i         : per-way scratchpad lock, sampled at acceptance
//   req_*              : request channel (mode, index, tag, dirty, flush way)
//   res_*              : response channel (hit, way, evict, evict tag)
//   init_done_o        : clear sweep finished
import axi_llc_pkg::*;

module axi_llc_tag_store_plru #(
    parameter int unsigned NumWays     = 4,
    parameter int unsigned NumLines    = 256,
    parameter int unsigned TagWidth    = 20,
    parameter int unsigned SramLatency = 1,
    localparam int unsigned IdxWidth   = $clog2(NumLines),
    localparam int unsigned DataWidth  = TagWidth + 2,
    localparam int unsigned CntWidth   = $clog2(SramLatency + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumWays-1:0]  spm_lock_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_mode_i,
    input  logic [IdxWidth-1:0] req_index_i,
    input  logic [TagWidth-1:0] req_tag_i,
    input  logic                req_dirty_i,
    input  logic [NumWays-1:0]  req_way_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic                res_hit_o,
    output logic [NumWays-1:0]  res_way_o,
    output logic                res_evict_o,
    output logic [TagWidth-1:0] res_evict_tag_o,
    output logic                init_done_o
);

    logic [1:0]           state_reg;
    logic [IdxWidth-1:0]  init_idx_reg;
    logic                 init_done_reg;
    logic [CntWidth-1:0]  lat_cnt_reg;
    tag_mode_e            mode_reg;
    logic [IdxWidth-1:0]  index_reg;
    logic [TagWidth-1:0]  tag_reg;
    logic                 dirty_reg;
    logic [NumWays-1:0]   way_reg;
    logic [NumWays-1:0]   lock_reg;
    logic                 res_hit_reg;
    logic [NumWays-1:0]   res_way_reg;
    logic                 res_evict_reg;
    logic [TagWidth-1:0]  res_evict_tag_reg;
    logic [NumWays-1:0]   wb_we_reg;
    logic [DataWidth-1:0] wb_data_reg;
    logic [NumWays-2:0]   plru_reg [NumLines];

    logic                 req_hs;
    logic                 res_hs;
    logic                 read_last;
    tag_data_t            rd_entry [NumWays];
    logic [NumWays-1:0]   hit_vec;
    logic [NumWays-1:0]   free_vec;
    logic [NumWays-1:0]   plru_victim;
    logic [NumWays-2:0]   plru_next;
    logic [NumWays-1:0]   victim;
    logic [NumWays-1:0]   unlocked;
    logic                 lookup_hit;
    logic [NumWays-1:0]   way_next;
    logic                 sel_val;
    logic                 sel_dit;
    logic [TagWidth-1:0]  sel_tag;
    logic                 evict_next;
    logic [NumWays-1:0]   wb_we_next;
    logic [DataWidth-1:0] wb_data_next;
    logic [IdxWidth-1:0]  sram_addr;
    logic [DataWidth-1:0] sram_wdata;
    logic                 sram_we;

    assign req_hs    = (state_reg == ST_IDLE) && req_valid_i;
    assign res_hs    = (state_reg == ST_RESP) && res_ready_i;
    assign read_last = (state_reg == ST_READ) && (lat_cnt_reg == CntWidth'(SramLatency - 1));

    // Only INIT and the response write-back write; IDLE issues reads.
    assign sram_we    = (state_reg == ST_INIT) || (state_reg == ST_RESP);
    assign sram_wdata = (state_reg == ST_INIT) ? '0 : wb_data_reg;
    assign sram_addr  = (state_reg == ST_INIT) ? init_idx_reg :
                        (state_reg == ST_IDLE) ? req_index_i  : index_reg;

    for (genvar gi = 0; gi < NumWays; gi++) begin : g_way
        logic [DataWidth-1:0] rdata;
        logic                 sram_req;

        // Gated by reset so an interrupted write-back never lands.
        assign sram_req = !rst_i && ((state_reg == ST_INIT) ||
                          (req_hs && (req_mode_i ? req_way_i[gi] : !spm_lock_i[gi])) ||
                          (res_hs && wb_we_reg[gi]));

        tc_sram #(
            .NumWords  (NumLines),
            .DataWidth (DataWidth),
            .Latency   (SramLatency)
        ) i_tag_sram (
            .clk_i   (clk_i),
            .req_i   (sram_req),
            .we_i    (sram_we),
            .addr_i  (sram_addr),
            .wdata_i (sram_wdata),
            .rdata_o (rdata)
        );

        assign rd_entry[gi] = {rdata[TagWidth+1], rdata[TagWidth], MaxTagWidth'(rdata[TagWidth-1:0])};
        assign hit_vec[gi]  = !lock_reg[gi] && rd_entry[gi].val &&
                              (rd_entry[gi].tag == MaxTagWidth'(tag_reg));
        assign free_vec[gi] = !lock_reg[gi] && !rd_entry[gi].val;
    end

    axi_llc_plru_tree #(
        .NumWays (NumWays)
    ) i_plru (
        .bits_i      (plru_reg[index_reg]),
        .access_i    (res_way_reg),
        .victim_o    (plru_victim),
        .next_bits_o (plru_next)
    );

    always_comb begin
        unlocked = ~lock_reg;
        if (|free_vec) begin
            victim = free_vec & (~free_vec + NumWays'(1));
        end else if (|(plru_victim & unlocked)) begin
            victim = plru_victim;
        end else begin
            victim = unlocked & (~unlocked + NumWays'(1));
        end

        lookup_hit = (mode_reg == TAG_LOOKUP) && (|hit_vec);
        if (mode_reg == TAG_FLUSH) begin
            way_next = way_reg;
        end else if (lookup_hit) begin
            way_next = hit_vec;
        end else begin
            way_next = victim;
        end

        sel_val = 1'b0;
        sel_dit = 1'b0;
        sel_tag = '0;
        for (int w = 0; w < NumWays; w++) begin
            if (way_next[w]) begin
                sel_val = sel_val | rd_entry[w].val;
                sel_dit = sel_dit | rd_entry[w].dit;
                sel_tag = sel_tag | rd_entry[w].tag[TagWidth-1:0];
            end
        end
        evict_next = !lookup_hit && sel_val && sel_dit;

        // A hit only needs writing when it turns a clean line dirty.
        wb_data_next = {1'b1, dirty_reg | lookup_hit, tag_reg};
        if (mode_reg == TAG_FLUSH) begin
            wb_we_next   = way_reg;
            wb_data_next = '0;
        end else if (lookup_hit) begin
            wb_we_next = (dirty_reg && !sel_dit) ? hit_vec : '0;
        end else begin
            wb_we_next = victim;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg         <= ST_INIT;
            init_idx_reg      <= '0;
            init_done_reg     <= 1'b0;
            lat_cnt_reg       <= '0;
            mode_reg          <= TAG_LOOKUP;
            index_reg         <= '0;
            tag_reg           <= '0;
            dirty_reg         <= 1'b0;
            way_reg           <= '0;
            lock_reg          <= '0;
            res_hit_reg       <= 1'b0;
            res_way_reg       <= '0;
            res_evict_reg     <= 1'b0;
            res_evict_tag_reg <= '0;
            wb_we_reg         <= '0;
            wb_data_reg       <= '0;
            for (int l = 0; l < NumLines; l++) begin
                plru_reg[l] <= '0;
            end
        end else begin
            case (state_reg)
                ST_INIT: begin
                    init_idx_reg <= init_idx_reg + IdxWidth'(1);
                    if (init_idx_reg == IdxWidth'(NumLines - 1)) begin
                        state_reg     <= ST_IDLE;
                        init_done_reg <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid_i) begin
                        mode_reg    <= tag_mode_e'(req_mode_i);
                        index_reg   <= req_index_i;
                        tag_reg     <= req_tag_i;
                        dirty_reg   <= req_dirty_i;
                        way_reg     <= req_way_i;
                        lock_reg    <= spm_lock_i;
                        lat_cnt_reg <= '0;
                        state_reg   <= ST_READ;
                    end
                end
                ST_READ: begin
                    lat_cnt_reg <= lat_cnt_reg + CntWidth'(1);
                    if (read_last) begin
                        state_reg         <= ST_RESP;
                        res_hit_reg       <= lookup_hit;
                        res_way_reg       <= way_next;
                        res_evict_reg     <= evict_next;
                        res_evict_tag_reg <= evict_next ? sel_tag : '0;
                        wb_we_reg         <= wb_we_next;
                        wb_data_reg       <= wb_data_next;
                    end
                end
                default: begin
                    if (res_ready_i) begin
                        state_reg         <= ST_IDLE;
                        res_hit_reg       <= 1'b0;
                        res_way_reg       <= '0;
                        res_evict_reg     <= 1'b0;
                        res_evict_tag_reg <= '0;
                        wb_we_reg         <= '0;
                        if (mode_reg == TAG_LOOKUP && (|res_way_reg)) begin
                            plru_reg[index_reg] <= plru_next;
                        end
                    end
                end
            endcase
        end
    end

    assign req_ready_o     = (state_reg == ST_IDLE);
    assign res_valid_o     = (state_reg == ST_RESP);
    assign res_hit_o       = res_hit_reg;
    assign res_way_o       = res_way_reg;
    assign res_evict_o     = res_evict_reg;
    assign res_evict_tag_o = res_evict_tag_reg;
    assign init_done_o     = init_done_reg;

    // A tag may be resident in at most one unlocked way of a set.
    a_single_hit: assert property (@(posedge clk_i) disable iff (rst_i)
        (read_last && mode_reg == TAG_LOOKUP) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_axi_llc_tag_store_plru.sv
// Randomised and directed bench for axi_llc_tag_store_plru against a
// behavioural model: per-set arrays of entries plus last-access timestamps,
// with the PLRU victim derived by descending into the half of the set whose
// most recent access is older.
module tb_axi_llc_tag_store_plru;

    localparam int NW  = 4;
    localparam int NL  = 256;
    localparam int TW  = 20;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NW-1:0] spm_lock = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_mode = 1'b0;
    logic [7:0]    req_index = '0;
    logic [TW-1:0] req_tag = '0;
    logic          req_dirty = 1'b0;
    logic [NW-1:0] req_way = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_hit;
    logic [NW-1:0] res_way;
    logic          res_evict;
    logic [TW-1:0] res_evict_tag;
    logic          init_done;

    always #5 clk = ~clk;

    axi_llc_tag_store_plru #(
        .NumWays     (NW),
        .NumLines    (NL),
        .TagWidth    (TW),
        .SramLatency (LAT)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .spm_lock_i      (spm_lock),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_mode_i      (req_mode),
        .req_index_i     (req_index),
        .req_tag_i       (req_tag),
        .req_dirty_i     (req_dirty),
        .req_way_i       (req_way),
        .res_valid_o     (res_valid),
        .res_ready_i     (res_ready),
        .res_hit_o       (res_hit),
        .res_way_o       (res_way),
        .res_evict_o     (res_evict),
        .res_evict_tag_o (res_evict_tag),
        .init_done_o     (init_done)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model state
    bit          m_val [NL][NW];
    bit          m_dit [NL][NW];
    int unsigned m_tag [NL][NW];
    int unsigned m_ts  [NL][NW];
    int unsigned ts_now;

    logic [NW-1:0] last_way;
    int unsigned   last_evtag;
    bit            last_ev;

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            for (int w = 0; w < NW; w++) begin
                m_val[l][w] = 0;
                m_dit[l][w] = 0;
                m_tag[l][w] = 0;
                m_ts[l][w]  = 0;
            end
        end
        ts_now = 0;
    endtask

    function automatic int plru_victim(input int idx);
        int lo;
        int size;
        int half;
        int unsigned ml;
        int unsigned mr;
        lo   = 0;
        size = NW;
        while (size > 1) begin
            half = size / 2;
            ml   = 0;
            mr   = 0;
            for (int k = 0; k < half; k++) begin
                if (m_ts[idx][lo+k] > ml) ml = m_ts[idx][lo+k];
                if (m_ts[idx][lo+half+k] > mr) mr = m_ts[idx][lo+half+k];
            end
            if (mr < ml) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    task automatic predict(input bit mode, input int idx, input int unsigned tag,
                           input logic [NW-1:0] way, input logic [NW-1:0] lock,
                           output bit e_hit, output logic [NW-1:0] e_way,
                           output bit e_ev, output int unsigned e_tag, output int w_sel);
        int pv;
        e_hit = 0; e_way = '0; e_ev = 0; e_tag = 0; w_sel = -1;
        if (mode) begin
            for (int w = 0; w < NW; w++) if (way[w]) w_sel = w;
            e_way = way;
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (!lock[w] && m_val[idx][w] && m_tag[idx][w] == tag) begin
                    e_hit = 1;
                    w_sel = w;
                end
            end
            if (!e_hit) begin
                for (int w = NW - 1; w >= 0; w--) if (!lock[w] && !m_val[idx][w]) w_sel = w;
                if (w_sel < 0) begin
                    pv = plru_victim(idx);
                    if (!lock[pv]) w_sel = pv;
                end
                if (w_sel < 0) begin
                    for (int w = NW - 1; w >= 0; w--) if (!lock[w]) w_sel = w;
                end
            end
            if (w_sel >= 0) e_way = NW'(1) << w_sel;
        end
        if (!e_hit && w_sel >= 0 && m_val[idx][w_sel] && m_dit[idx][w_sel]) begin
            e_ev  = 1;
            e_tag = m_tag[idx][w_sel];
        end
    endtask

    task automatic check_res(input string name, input bit e_hit, input logic [NW-1:0] e_way,
                             input bit e_ev, input int unsigned e_tag);
        check($sformatf("%s.valid", name), res_valid, 1);
        check($sformatf("%s.ready_busy", name), req_ready, 0);
        check($sformatf("%s.hit", name), res_hit, e_hit);
        check($sformatf("%s.way", name), res_way, e_way);
        check($sformatf("%s.evict", name), res_evict, e_ev);
        check($sformatf("%s.evict_tag", name), res_evict_tag, e_tag);
    endtask

    task automatic do_txn(input bit mode, input int idx, input int unsigned tag, input bit dirty,
                          input logic [NW-1:0] way, input logic [NW-1:0] lock, input int hold,
                          input string name);
        int n;
        int w_sel;
        bit e_hit;
        bit e_ev;
        logic [NW-1:0] e_way;
        int unsigned e_tag;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check($sformatf("%s.ready_timeout", name), 0, 1);
            return;
        end
        req_mode  = mode;
        req_index = idx[7:0];
        req_tag   = tag[TW-1:0];
        req_dirty = dirty;
        req_way   = way;
        spm_lock  = lock;
        req_valid = 1'b1;
        predict(mode, idx, tag, way, lock, e_hit, e_way, e_ev, e_tag, w_sel);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        spm_lock  = NW'($urandom);  // must be ignored while busy
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 50);
        check($sformatf("%s.latency", name), n, LAT + 1);
        check_res(name, e_hit, e_way, e_ev, e_tag);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_res($sformatf("%s.hold%0d", name, h), e_hit, e_way, e_ev, e_tag);
        end
        last_way   = res_way;
        last_evtag = res_evict_tag;
        last_ev    = res_evict;
        $display("txn %s mode=%0d idx=%0d tag=%0h dirty=%0b -> hit=%0b way=%b evict=%0b evict_tag=%0h",
                 name, mode, idx, tag, dirty, res_hit, res_way, res_evict, res_evict_tag);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check($sformatf("%s.valid_after", name), res_valid, 0);
        check($sformatf("%s.way_after", name), res_way, 0);
        // Commit to model
        if (mode) begin
            if (w_sel >= 0) begin
                m_val[idx][w_sel] = 0;
                m_dit[idx][w_sel] = 0;
                m_tag[idx][w_sel] = 0;
            end
        end else if (w_sel >= 0) begin
            if (e_hit) begin
                if (dirty) m_dit[idx][w_sel] = 1;
            end else begin
                m_val[idx][w_sel] = 1;
                m_dit[idx][w_sel] = dirty;
                m_tag[idx][w_sel] = tag;
            end
            ts_now++;
            m_ts[idx][w_sel] = ts_now;
        end
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        @(negedge clk);
        check($sformatf("%s.done_early", name), init_done, 0);
        while (!req_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("%s.cycles", name), n, NL);
        check($sformatf("%s.done", name), init_done, 1);
        $display("txn %s init_cycles=%0d init_done=%0b", name, n, init_done);
    endtask

    initial begin
        bit          md;
        int          idx;
        int unsigned tg;
        int          n;

        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ready", req_ready, 0);
        check("reset.valid", res_valid, 0);
        check("reset.init_done", init_done, 0);
        check("reset.hit", res_hit, 0);
        check("reset.way", res_way, 0);
        check("reset.evict", res_evict, 0);
        check("reset.evict_tag", res_evict_tag, 0);
        rst = 1'b0;
        wait_init("init");

        // Miss then hit
        do_txn(0, 5, 'h123, 0, '0, '0, 0, "miss5");
        check("miss5.literal_way", last_way, 4'b0001);
        do_txn(0, 5, 'h123, 0, '0, '0, 0, "hit5");

        // Fill a set with dirty lines and force a PLRU eviction
        for (int t = 0; t < 4; t++) do_txn(0, 7, 'h10 + t, 1, '0, '0, 0, $sformatf("fill7_%0d", t));
        do_txn(0, 7, 'h14, 0, '0, '0, 0, "evict7");
        check("evict7.literal_way", last_way, 4'b0001);
        check("evict7.literal_tag", last_evtag, 'h10);
        check("evict7.literal_ev", last_ev, 1);

        // Scratchpad locking
        do_txn(0, 20, 'h1, 0, '0, 4'b1111, 0, "lock_all");
        do_txn(0, 21, 'h55, 0, '0, '0, 0, "lock_prep");
        do_txn(0, 21, 'h55, 0, '0, 4'b0001, 0, "lock_w0");
        check("lock_w0.not_way0", last_way[0], 0);

        // Flush a dirty line
        do_txn(0, 9, 'h111, 0, '0, '0, 0, "flush_prep0");
        do_txn(0, 9, 'hABC, 1, '0, '0, 0, "flush_prep1");
        do_txn(1, 9, 0, 0, 4'b0010, '0, 0, "flush");
        check("flush.literal_tag", last_evtag, 'hABC);
        do_txn(0, 9, 'hABC, 0, '0, '0, 0, "flush_after");

        // Back-pressure
        do_txn(0, 30, 'h77, 1, '0, '0, 10, "bp");
        do_txn(0, 30, 'h77, 0, '0, '0, 0, "bp_after");

        // Randomised traffic over a few congested sets
        for (int i = 0; i < 80; i++) begin
            md  = ($urandom_range(0, 4) == 0);
            idx = $urandom_range(0, 3);
            tg  = $urandom_range(0, 7);
            do_txn(md, idx, tg, 1'($urandom_range(0, 1)), NW'(1) << $urandom_range(0, NW - 1),
                   '0, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        // Reset while a response is pending
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_mode  = 1'b0;
        req_index = 8'd40;
        req_tag   = 'h99;
        req_dirty = 1'b1;
        spm_lock  = '0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 50);
        check("rst_resp.valid_before", res_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_resp.valid", res_valid, 0);
        check("rst_resp.ready", req_ready, 0);
        check("rst_resp.init_done", init_done, 0);
        check("rst_resp.way", res_way, 0);
        $display("txn rst_resp valid=%0b ready=%0b init_done=%0b", res_valid, req_ready, init_done);
        rst = 1'b0;
        model_reset();
        wait_init("reinit");
        do_txn(0, 40, 'h99, 0, '0, '0, 0, "post_reset");
        do_txn(0, 7, 'h11, 0, '0, '0, 0, "post_reset7");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
